processing_element_is_db: RTL and testbench

- Next-generation input-stationary PE for the systolic array, with LANES activations held stationary.
- A double-buffered (shadow/active) activation store lets the next activation tile preload while the current one computes.
- Each weight beat runs a LANES-wide dot product. Weight and valid are forwarded horizontally with 1-cycle latency; partial sums flow vertically with fixed STAGE+1 latency.
- No backpressure: the pipeline always advances and carries valid bubbles.

---
 rtl/processing_element_is_db.sv | 220 ++++++++++++++++++++++
 tb/tb_processing_element_is_db.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/processing_element_is_db.sv
// Input-stationary PE: double-buffered activation bank, LANES-wide dot product per weight beat,
// systolic forwarding of activations/weights and a fixed STAGE+1 latency partial-sum path.
module processing_element_is_db #(
  parameter int unsigned WIDTH_A     = 16,
  parameter int unsigned WIDTH_B     = 16,
  parameter int unsigned WIDTH_MAC   = 48,
  parameter int unsigned LANES       = 2,
  parameter int unsigned STAGE       = 1,
  parameter int unsigned SIGNED      = 0,
  parameter int unsigned ZERO_GATING = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic [LANES*WIDTH_A-1:0]   act_in,
  input  logic                       act_load,
  input  logic                       act_swap,
  input  logic [LANES*WIDTH_B-1:0]   wei_in,
  input  logic                       wei_valid,
  input  logic [WIDTH_MAC-1:0]       psum_in,
  output logic [LANES*WIDTH_A-1:0]   act_out,
  output logic                       act_load_out,
  output logic                       act_swap_out,
  output logic [LANES*WIDTH_B-1:0]   wei_out,
  output logic                       wei_valid_out,
  output logic [WIDTH_MAC-1:0]       psum_out,
  output logic                       psum_valid_out,
  output logic                       act_ready,
  output logic                       shadow_full,
  output logic [1:0]                 err
);

  localparam int unsigned PW = WIDTH_A + WIDTH_B;
  localparam int unsigned AW = LANES * WIDTH_A;
  localparam int unsigned BW = LANES * WIDTH_B;

  logic [AW-1:0]        shadow_q, shadow_d, active_q, active_d;
  logic                 act_ready_q, act_ready_d, shadow_full_q, shadow_full_d;
  logic [1:0]           err_q, err_d;
  logic [AW-1:0]        act_out_q, act_out_d;
  logic                 act_load_out_q, act_load_out_d, act_swap_out_q, act_swap_out_d;
  logic [BW-1:0]        wei_out_q, wei_out_d;
  logic                 wei_valid_out_q, wei_valid_out_d;
  logic [WIDTH_MAC-1:0] psum_out_q, psum_out_d;
  logic                 psum_valid_out_q, psum_valid_out_d;

  logic [WIDTH_A-1:0]   a_l;
  logic [WIDTH_B-1:0]   b_l;
  logic [PW-1:0]        a_ext, b_ext, prod_l;
  logic signed [PW-1:0] prod_s;
  logic [WIDTH_MAC-1:0] prod_ext, issue_prod;
  logic [WIDTH_MAC-1:0] tail_prod, tail_psum;
  logic                 tail_vld;

  // Lane products against the pre-edge active bank; gated lanes contribute exactly zero.
  always_comb begin
    issue_prod = '0;
    a_l        = '0;
    b_l        = '0;
    a_ext      = '0;
    b_ext      = '0;
    prod_l     = '0;
    prod_s     = '0;
    prod_ext   = '0;
    for (int unsigned l = 0; l < LANES; l++) begin
      a_l      = active_q[l*WIDTH_A +: WIDTH_A];
      b_l      = wei_in[l*WIDTH_B +: WIDTH_B];
      prod_ext = '0;
      if (act_ready_q && !((ZERO_GATING != 0) && (a_l == '0 || b_l == '0))) begin
        a_ext  = {{WIDTH_B{(SIGNED != 0) && a_l[WIDTH_A-1]}}, a_l};
        b_ext  = {{WIDTH_A{(SIGNED != 0) && b_l[WIDTH_B-1]}}, b_l};
        prod_l = PW'(a_ext * b_ext);
        prod_s = prod_l;
        if (SIGNED != 0) prod_ext = WIDTH_MAC'(prod_s);
        else             prod_ext = WIDTH_MAC'(prod_l);
      end
      issue_prod = issue_prod + prod_ext;
    end
  end

  if (STAGE > 0) begin : g_pipe
    logic [WIDTH_MAC-1:0] prod_q [STAGE];
    logic [WIDTH_MAC-1:0] prod_d [STAGE];
    logic [WIDTH_MAC-1:0] psum_q [STAGE];
    logic [WIDTH_MAC-1:0] psum_d [STAGE];
    logic [STAGE-1:0]     vld_q, vld_d;

    // Shift register carrying reduced products, partial sums and valids.
    always_comb begin
      prod_d[0] = issue_prod;
      psum_d[0] = psum_in;
      vld_d[0]  = wei_valid;
      for (int unsigned i = 1; i < STAGE; i++) begin
        prod_d[i] = prod_q[i-1];
        psum_d[i] = psum_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
      if (clear) begin
        for (int unsigned i = 0; i < STAGE; i++) begin
          prod_d[i] = '0;
          psum_d[i] = '0;
        end
        vld_d = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < STAGE; i++) begin
          prod_q[i] <= '0;
          psum_q[i] <= '0;
        end
        vld_q <= '0;
      end else begin
        for (int unsigned i = 0; i < STAGE; i++) begin
          prod_q[i] <= prod_d[i];
          psum_q[i] <= psum_d[i];
        end
        vld_q <= vld_d;
      end
    end

    assign tail_prod = prod_q[STAGE-1];
    assign tail_psum = psum_q[STAGE-1];
    assign tail_vld  = vld_q[STAGE-1];
  end else begin : g_nopipe
    assign tail_prod = issue_prod;
    assign tail_psum = psum_in;
    assign tail_vld  = wei_valid;
  end

  // Bank management, forwarding and final accumulate.
  always_comb begin
    shadow_d         = shadow_q;
    active_d         = active_q;
    act_ready_d      = act_ready_q;
    shadow_full_d    = shadow_full_q;
    err_d            = err_q;
    act_out_d        = act_in;
    act_load_out_d   = act_load;
    act_swap_out_d   = act_swap;
    wei_out_d        = wei_in;
    wei_valid_out_d  = wei_valid;
    psum_out_d       = psum_out_q;
    psum_valid_out_d = tail_vld;
    if (tail_vld) psum_out_d = tail_psum + tail_prod;

    if (act_swap) begin
      if (shadow_full_q) begin
        active_d      = shadow_q;
        act_ready_d   = 1'b1;
        shadow_full_d = 1'b0;
      end else if (!act_load) begin
        err_d[0] = 1'b1;
      end
    end
    if (act_load) begin
      shadow_d      = act_in;
      shadow_full_d = 1'b1;
      if (shadow_full_q && !act_swap) err_d[1] = 1'b1;
    end

    if (clear) begin
      shadow_d         = '0;
      active_d         = '0;
      act_ready_d      = 1'b0;
      shadow_full_d    = 1'b0;
      err_d            = '0;
      act_out_d        = '0;
      act_load_out_d   = 1'b0;
      act_swap_out_d   = 1'b0;
      wei_out_d        = '0;
      wei_valid_out_d  = 1'b0;
      psum_out_d       = '0;
      psum_valid_out_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q         <= '0;
      active_q         <= '0;
      act_ready_q      <= 1'b0;
      shadow_full_q    <= 1'b0;
      err_q            <= '0;
      act_out_q        <= '0;
      act_load_out_q   <= 1'b0;
      act_swap_out_q   <= 1'b0;
      wei_out_q        <= '0;
      wei_valid_out_q  <= 1'b0;
      psum_out_q       <= '0;
      psum_valid_out_q <= 1'b0;
    end else begin
      shadow_q         <= shadow_d;
      active_q         <= active_d;
      act_ready_q      <= act_ready_d;
      shadow_full_q    <= shadow_full_d;
      err_q            <= err_d;
      act_out_q        <= act_out_d;
      act_load_out_q   <= act_load_out_d;
      act_swap_out_q   <= act_swap_out_d;
      wei_out_q        <= wei_out_d;
      wei_valid_out_q  <= wei_valid_out_d;
      psum_out_q       <= psum_out_d;
      psum_valid_out_q <= psum_valid_out_d;
    end
  end

  assign act_out        = act_out_q;
  assign act_load_out   = act_load_out_q;
  assign act_swap_out   = act_swap_out_q;
  assign wei_out        = wei_out_q;
  assign wei_valid_out  = wei_valid_out_q;
  assign psum_out       = psum_out_q;
  assign psum_valid_out = psum_valid_out_q;
  assign act_ready      = act_ready_q;
  assign shadow_full    = shadow_full_q;
  assign err            = err_q;

endmodule

// File: tb/tb_processing_element_is_db.sv
// Directed bench for processing_element_is_db: default unsigned PE, a ZERO_GATING=0 twin on the
// same inputs, and a SIGNED LANES=1 STAGE=0 instance.
module tb_processing_element_is_db;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for the two LANES=2 instances.
  logic        clear, act_load, act_swap, wei_valid;
  logic [31:0] act_in, wei_in;
  logic [47:0] psum_in;

  logic [31:0] act_out, wei_out, g_act_out, g_wei_out;
  logic        act_load_out, act_swap_out, wei_valid_out, psum_valid_out, act_ready, shadow_full;
  logic        g_act_load_out, g_act_swap_out, g_wei_valid_out, g_psum_valid_out, g_act_ready, g_shadow_full;
  logic [47:0] psum_out, g_psum_out;
  logic [1:0]  err, g_err;

  // Signed single-lane instance.
  logic        s_act_load, s_act_swap, s_wei_valid;
  logic [15:0] s_act_in, s_wei_in, s_act_out, s_wei_out;
  logic [47:0] s_psum_in, s_psum_out;
  logic        s_act_load_out, s_act_swap_out, s_wei_valid_out, s_psum_valid_out, s_act_ready, s_shadow_full;
  logic [1:0]  s_err;

  int n_cmp = 0;
  int n_err = 0;

  processing_element_is_db dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .act_in(act_in), .act_load(act_load),
    .act_swap(act_swap), .wei_in(wei_in), .wei_valid(wei_valid), .psum_in(psum_in),
    .act_out(act_out), .act_load_out(act_load_out), .act_swap_out(act_swap_out),
    .wei_out(wei_out), .wei_valid_out(wei_valid_out), .psum_out(psum_out),
    .psum_valid_out(psum_valid_out), .act_ready(act_ready), .shadow_full(shadow_full), .err(err)
  );

  processing_element_is_db #(.ZERO_GATING(0)) u_nogate (
    .clk(clk), .rst_n(rst_n), .clear(clear), .act_in(act_in), .act_load(act_load),
    .act_swap(act_swap), .wei_in(wei_in), .wei_valid(wei_valid), .psum_in(psum_in),
    .act_out(g_act_out), .act_load_out(g_act_load_out), .act_swap_out(g_act_swap_out),
    .wei_out(g_wei_out), .wei_valid_out(g_wei_valid_out), .psum_out(g_psum_out),
    .psum_valid_out(g_psum_valid_out), .act_ready(g_act_ready), .shadow_full(g_shadow_full), .err(g_err)
  );

  processing_element_is_db #(.LANES(1), .STAGE(0), .SIGNED(1)) u_signed (
    .clk(clk), .rst_n(rst_n), .clear(1'b0), .act_in(s_act_in), .act_load(s_act_load),
    .act_swap(s_act_swap), .wei_in(s_wei_in), .wei_valid(s_wei_valid), .psum_in(s_psum_in),
    .act_out(s_act_out), .act_load_out(s_act_load_out), .act_swap_out(s_act_swap_out),
    .wei_out(s_wei_out), .wei_valid_out(s_wei_valid_out), .psum_out(s_psum_out),
    .psum_valid_out(s_psum_valid_out), .act_ready(s_act_ready), .shadow_full(s_shadow_full), .err(s_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clear = 1'b0; act_load = 1'b0; act_swap = 1'b0; wei_valid = 1'b0;
    s_act_load = 1'b0; s_act_swap = 1'b0; s_wei_valid = 1'b0;
  endtask

  task automatic load_swap(input logic [31:0] a);
    act_in = a; act_load = 1'b1; tick();
    act_load = 1'b0; act_swap = 1'b1; tick();
    act_swap = 1'b0;
  endtask

  task automatic beat(input logic [31:0] w, input logic [47:0] p);
    wei_in = w; psum_in = p; wei_valid = 1'b1;
  endtask

  initial begin
    idle();
    act_in = '0; wei_in = '0; psum_in = '0;
    s_act_in = '0; s_wei_in = '0; s_psum_in = '0;
    rst_n = 1'b0;
    #12;
    check("rst_psum_out", 64'(psum_out), 64'd0);
    check("rst_psum_vld", 64'(psum_valid_out), 64'd0);
    check("rst_act_ready", 64'(act_ready), 64'd0);
    check("rst_shadow_full", 64'(shadow_full), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic dot product: act {3,5}, wei {2,4}, psum 10 -> 36
    act_in = {16'd5, 16'd3}; act_load = 1'b1; tick();
    check("load_shadow_full", 64'(shadow_full), 64'd1);
    check("load_act_ready", 64'(act_ready), 64'd0);
    check("fwd_act_load", 64'(act_load_out), 64'd1);
    check("fwd_act_out", 64'(act_out), 64'h0005_0003);
    act_load = 1'b0; act_swap = 1'b1; tick();
    check("swap_act_ready", 64'(act_ready), 64'd1);
    check("swap_shadow_full", 64'(shadow_full), 64'd0);
    check("fwd_act_swap", 64'(act_swap_out), 64'd1);
    act_swap = 1'b0;
    beat({16'd4, 16'd2}, 48'd10); tick();
    wei_valid = 1'b0;
    check("fwd_wei_out", 64'(wei_out), 64'h0004_0002);
    check("fwd_wei_vld", 64'(wei_valid_out), 64'd1);
    check("dot_vld_early", 64'(psum_valid_out), 64'd0);
    tick();
    check("dot_psum", 64'(psum_out), 64'd36);
    check("dot_vld", 64'(psum_valid_out), 64'd1);
    check("dot_psum_nogate", 64'(g_psum_out), 64'd36);
    tick();
    check("dot_vld_once", 64'(psum_valid_out), 64'd0);
    check("dot_psum_hold", 64'(psum_out), 64'd36);

    // Modular wrap with a gated lane
    load_swap({16'd0, 16'd1});
    beat({16'd9, 16'd1}, 48'hFFFF_FFFF_FFFF); tick();
    wei_valid = 1'b0; tick();
    check("wrap_psum", 64'(psum_out), 64'd0);
    check("wrap_vld", 64'(psum_valid_out), 64'd1);
    check("wrap_psum_nogate", 64'(g_psum_out), 64'd0);

    // Ping-pong: active {1,1}, shadow {2,2}, swap alongside the second beat
    load_swap({16'd1, 16'd1});
    act_in = {16'd2, 16'd2}; act_load = 1'b1; tick();
    act_load = 1'b0;
    beat({16'd1, 16'd1}, 48'd0); tick();
    act_swap = 1'b1; tick();
    act_swap = 1'b0;
    check("pp_first", 64'(psum_out), 64'd2);
    check("pp_first_vld", 64'(psum_valid_out), 64'd1);
    tick();
    wei_valid = 1'b0;
    check("pp_second", 64'(psum_out), 64'd2);
    check("pp_second_vld", 64'(psum_valid_out), 64'd1);
    tick();
    check("pp_third", 64'(psum_out), 64'd4);
    check("pp_third_vld", 64'(psum_valid_out), 64'd1);

    // Load and swap together
    act_in = {16'd7, 16'd7}; act_load = 1'b1; tick();
    act_in = {16'd8, 16'd8}; act_swap = 1'b1; tick();
    idle();
    check("ls_err", 64'(err), 64'd0);
    check("ls_shadow_full", 64'(shadow_full), 64'd1);
    beat({16'd1, 16'd1}, 48'd0); tick();
    wei_valid = 1'b0; tick();
    check("ls_active", 64'(psum_out), 64'd14);

    // Errors: promote {8,8}, then swap on empty shadow
    act_swap = 1'b1; tick();
    tick();
    act_swap = 1'b0;
    check("err_swap_empty", 64'(err), 64'd1);
    beat({16'd1, 16'd1}, 48'd0); tick();
    wei_valid = 1'b0; tick();
    check("err_active_kept", 64'(psum_out), 64'd16);
    act_in = {16'd2, 16'd3}; act_load = 1'b1; tick();
    tick();
    act_load = 1'b0;
    check("err_overwrite", 64'(err), 64'd3);
    clear = 1'b1; act_load = 1'b1; tick();
    idle();
    check("clr_err", 64'(err), 64'd0);
    check("clr_shadow_full", 64'(shadow_full), 64'd0);
    check("clr_act_ready", 64'(act_ready), 64'd0);
    check("clr_psum_out", 64'(psum_out), 64'd0);

    // Reset mid-flight
    load_swap({16'd3, 16'd2});
    beat({16'd1, 16'd1}, 48'd5); tick();
    wei_valid = 1'b0;
    rst_n = 1'b0; #3;
    check("rmf_wei_out", 64'(wei_out), 64'd0);
    check("rmf_act_ready", 64'(act_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rmf_no_vld", 64'(psum_valid_out), 64'd0);
    check("rmf_psum_out", 64'(psum_out), 64'd0);
    beat({16'd3, 16'd3}, 48'd77); tick();
    wei_valid = 1'b0; tick();
    check("rmf_passthru", 64'(psum_out), 64'd77);
    check("rmf_passthru_vld", 64'(psum_valid_out), 64'd1);

    // Signed single lane, STAGE=0
    s_act_in = 16'hFFFD; s_act_load = 1'b1; tick();
    s_act_load = 1'b0; s_act_swap = 1'b1; tick();
    s_act_swap = 1'b0;
    s_wei_in = 16'd7; s_psum_in = 48'd0; s_wei_valid = 1'b1; tick();
    check("sgn_neg_pos", 64'(s_psum_out), 64'h0000_FFFF_FFFF_FFEB);
    check("sgn_vld", 64'(s_psum_valid_out), 64'd1);
    s_wei_in = 16'hFFFE; tick();
    s_wei_valid = 1'b0;
    check("sgn_neg_neg", 64'(s_psum_out), 64'd6);
    tick();
    check("sgn_vld_drop", 64'(s_psum_valid_out), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
